// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the
// canned stall/flush control patterns driven onto the pipeline registers.
package pipeline_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    localparam int unsigned RegAwDefault = 4;

    // en/flush bit order: {ifid, idex, exmem, memwb}
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] flush;
    } ctrl_t;

    // All-zero control word loaded into a flushed pipeline register
    localparam logic [3:0] Bubble = 4'b0000;

    localparam ctrl_t CtrlReset  = '{pc_en: 1'b0, en: 4'b1111, flush: 4'b1111};
    localparam ctrl_t CtrlRun    = '{pc_en: 1'b1, en: 4'b1111, flush: Bubble};
    localparam ctrl_t CtrlFreeze = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b0001};
    localparam ctrl_t CtrlBranch = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b1110};
    localparam ctrl_t CtrlLoadUse = '{pc_en: 1'b0, en: 4'b0111, flush: 4'b0100};
    localparam ctrl_t CtrlHalt   = '{pc_en: 1'b0, en: 4'b0000, flush: Bubble};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the
// instruction waiting in IF/ID.
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = RegAwDefault
) (
    input  logic              idex_mr,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use_rs2,
    output logic              luh
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard
    assign luh = idex_mr && (idex_rd != '0) &&
                 ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
// load-use stalls, taken-branch flushes, memory-wait freezes with timeout.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW  = RegAwDefault,
    parameter int unsigned MEM_TMO = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use_rs2,
    input  logic              idex_mr,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_mr,
    input  logic              exmem_mw,
    input  logic              branch_taken,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [7:0] TmoVal = 8'(MEM_TMO);

    state_e     state_q;
    logic [7:0] wait_cnt_q;
    logic       luh;
    logic       memreq;
    logic       mem_stall;
    ctrl_t      ctrl;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .idex_mr     (idex_mr),
        .idex_rd     (idex_rd),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2),
        .ifid_use_rs2(ifid_use_rs2),
        .luh         (luh)
    );

    assign memreq    = exmem_mr | exmem_mw;
    assign mem_stall = !mem_ready && ((state_q == StRun && memreq) || state_q == StMemWait);

    always_comb begin
        ctrl = CtrlRun;
        if (!rst_n) begin
            ctrl = CtrlReset;
        end else if (state_q == StErr) begin
            ctrl = CtrlHalt;
        end else if (mem_stall) begin
            ctrl = CtrlFreeze;
        end else if (branch_taken) begin
            ctrl = CtrlBranch;
        end else if (luh) begin
            ctrl = CtrlLoadUse;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.en[3];
    assign idex_en     = ctrl.en[2];
    assign exmem_en    = ctrl.en[1];
    assign memwb_en    = ctrl.en[0];
    assign ifid_flush  = ctrl.flush[3];
    assign idex_flush  = ctrl.flush[2];
    assign exmem_flush = ctrl.flush[1];
    assign memwb_flush = ctrl.flush[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (state_q != StErr && !pc_en && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            unique case (state_q)
                StRun: begin
                    if (memreq && !mem_ready) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= 8'd1;
                    end
                end
                StMemWait: begin
                    if (mem_ready) begin
                        state_q    <= StRun;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == TmoVal) begin
                        state_q <= StErr;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios then
// randomized traffic, all compared against a behavioural model of the rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW   = 4;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CW   = 4;
    localparam int          SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ifid_rs1, ifid_rs2, idex_rd;
    logic          ifid_use_rs2, idex_mr, exmem_mr, exmem_mw, branch_taken, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW (AW),
        .MEM_TMO(TMO),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2),
        .ifid_use_rs2(ifid_use_rs2),
        .idex_mr     (idex_mr),
        .idex_rd     (idex_rd),
        .exmem_mr    (exmem_mr),
        .exmem_mw    (exmem_mw),
        .branch_taken(branch_taken),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    // Reference model: waiting = inside a memory access, waited = cycles spent
    // in the wait state so far, halted = timed out.
    bit waiting, halted;
    int waited, stalls;
    int n_cmp = 0;
    int n_fail = 0;

    function automatic bit m_luh();
        return idex_mr && idex_rd != 0 &&
               (idex_rd == ifid_rs1 || (ifid_use_rs2 && idex_rd == ifid_rs2));
    endfunction

    // Returns {pc_en, en ifid..memwb, flush ifid..memwb}
    function automatic logic [8:0] m_ctrl();
        bit memreq = exmem_mr || exmem_mw;
        if (!rst_n)                                   return 9'b0_1111_1111;
        if (halted)                                   return 9'b0_0000_0000;
        if (!mem_ready && (waiting || memreq))        return 9'b0_0000_0001;
        if (branch_taken)                             return 9'b1_1111_1110;
        if (m_luh())                                  return 9'b0_0111_0100;
        return 9'b1_1111_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic advance(input bit pc);
        if (!rst_n) return;
        if (!halted && !pc && stalls < SMAX) stalls++;
        if (halted) return;
        if (!waiting) begin
            if ((exmem_mr || exmem_mw) && !mem_ready) begin
                waiting = 1;
                waited  = 1;
            end
        end else if (mem_ready) begin
            waiting = 0;
            waited  = 0;
        end else if (waited >= TMO) begin
            halted = 1;
        end else begin
            waited++;
        end
    endtask

    task automatic step(input string tag);
        logic [8:0] e;
        if (!rst_n) begin
            waiting = 0; halted = 0; waited = 0; stalls = 0;
        end
        @(negedge clk);
        e = m_ctrl();
        check({tag, "/ctrl"}, {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                               ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'(e));
        check({tag, "/err"}, 32'(mem_err), 32'(halted));
        check({tag, "/cnt"}, 32'(stall_cnt), 32'(stalls));
        @(posedge clk);
        #1;
        advance(e[8]);
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit use2, input bit mr,
                          input int rd, input bit xmr, input bit xmw, input bit br,
                          input bit rdy);
        ifid_rs1 = AW'(rs1); ifid_rs2 = AW'(rs2); ifid_use_rs2 = use2;
        idex_mr = mr; idex_rd = AW'(rd);
        exmem_mr = xmr; exmem_mw = xmw; branch_taken = br; mem_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("reset0");
        step("reset1");
        rst_n = 1'b1;
        step("run_idle");

        set_in(5, 1, 0, 1, 5, 0, 0, 0, 1);
        step("luh_rs1");
        set_in(1, 2, 1, 0, 0, 0, 0, 0, 1);
        step("luh_after");
        check("luh_cnt_direct", 32'(stall_cnt), 32'd1);

        set_in(0, 3, 1, 1, 0, 0, 0, 0, 1);
        step("rd_zero");
        set_in(1, 6, 0, 1, 6, 0, 0, 0, 1);
        step("rs2_unused");
        set_in(1, 6, 1, 1, 6, 0, 0, 0, 1);
        step("rs2_used");

        set_in(7, 0, 0, 1, 7, 0, 0, 1, 1);
        step("branch_luh");

        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("memwait");
        mem_ready = 1'b1;
        step("memdone");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("memafter");

        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < TMO + 4; i++) step("timeout");
        mem_ready = 1'b1;
        step("err_sticky");
        check("err_direct", 32'(mem_err), 32'd1);
        rst_n = 1'b0;
        step("err_reset");
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("err_cleared");

        for (int i = 0; i < 600; i++) begin
            rst_n = halted ? ($urandom % 6 != 0) : ($urandom % 60 != 0);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom % 2, $urandom % 2,
                   $urandom_range(0, 3), $urandom % 8 == 0, $urandom % 8 == 0,
                   $urandom % 5 == 0, $urandom % 4 != 0);
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
